serial_adder: RTL

- Bit-serial adder front end for the team's 1-bit full-adder cell.
- Loads two WIDTH-bit operands and a carry-in, then feeds one bit pair per clock, LSB first, through a single full-adder slice.
- Holds the carry in a flip-flop and reassembles the sum bits in a shift register.
- Presents the registered result with a done pulse; used where area matters more than latency.

---
 rtl/serial_adder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice, LSB first, WIDTH+1 cycles per add.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             s_bit, c_bit;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   // The full-adder slice always looks at the current LSBs; only SHIFT uses it.
   always_comb begin
      s_bit = a_q[0] ^ b_q[0] ^ carry_q;
      c_bit = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_sh_d = sum_sh_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d    = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sum_sh_d = {s_bit, sum_sh_q[WIDTH-1:1]};
            a_d      = {1'b0, a_q[WIDTH-1:1]};
            b_d      = {1'b0, b_q[WIDTH-1:1]};
            carry_d  = c_bit;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               sum_d   = sum_sh_d;
               cout_d  = c_bit;
`ifdef SERIAL_ADDER_OVF_EN
               // On the MSB, carry_q is the carry into it and c_bit the carry out.
               ovf_d   = carry_q ^ c_bit;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sum_sh_q <= sum_sh_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule
